cdiv_issue_ctrl: RTL
====================

// Module: cdiv_issue_ctrl
// PURPOSE
//  Initiator-side controller for the complex_div unit: accepts jobs {a,b,c,d,id}, drives the divider's
//  in_valid/in_ready handshake, and collects {re,im,status} results. Results are buffered and returned
//  with the matching job id. Credit-based issue keeps out_ready_i to the divider permanently high.
//  Also detects a hung divider and recovers with a flush.
// PARAMETERS
//  WIDTH        64    operand/result width (FP64)
//  ID_W         4     job id width
//  MAX_OUT      4     max jobs in flight inside the divider (power of 2, >=2)
//  RSP_DEPTH    4     response FIFO depth (power of 2, >=MAX_OUT)
//  TIMEOUT      1024  cycles without a divider result while jobs are in flight before flush
// PORTS
//  clk_i           in   1            clock, all logic rising-edge
//  rst_i           in   1            synchronous, active-high reset
//  flush_i         in   1            software flush: drop in-flight jobs and buffered responses
//  job_valid_i     in   1            job offered
//  job_ready_o     out  1            job accepted when valid&ready
//  job_ops_i       in   4*WIDTH      [0]=a [1]=b [2]=c [3]=d, FP64; computes (a+jb)/(c+jd)
//  job_id_i        in   ID_W         job tag
//  div_valid_o     out  1            to complex_div in_valid_i
//  div_ready_i     in   1            from complex_div in_ready_o
//  div_ops_o       out  4*WIDTH      to complex_div operands_i
//  div_flush_o     out  1            to complex_div flush_i
//  div_out_valid_i in   1            from complex_div out_valid_o
//  div_out_ready_o out  1            to complex_div out_ready_i
//  div_result_i    in   2*WIDTH      from complex_div result_o, [0]=re [1]=im
//  div_status_i    in   5            fpnew status {NV,DZ,OF,UF,NX}
//  rsp_valid_o     out  1            response available
//  rsp_ready_i     in   1            response consumed when valid&ready
//  rsp_result_o    out  2*WIDTH      {im,re}
//  rsp_status_o    out  5            status of this result
//  rsp_id_o        out  ID_W         id of the job producing this result
//  inflight_o      out  $clog2(MAX_OUT)+1  jobs issued, result not yet captured
//  timeout_o       out  1            sticky; set on timeout, cleared only by rst_i
// BEHAVIOUR
//  Reset: all outputs 0 except div_out_ready_o=1; FSM=IDLE; FIFOs empty; counters 0.
//  Pass-through issue: div_valid_o=job_valid_i&credit&(state!=FLUSH); job_ready_o=div_ready_i&credit&(state!=FLUSH);
//   div_ops_o=job_ops_i. Zero-latency, no register stage. Issue event = div_valid_o&div_ready_i.
//  credit = (inflight<MAX_OUT) & (inflight+rsp_count<RSP_DEPTH). Guarantees every result has a slot.
//  On issue, job_id_i pushed into in-order id FIFO (depth MAX_OUT); inflight++.
//  Capture event = div_out_valid_i (div_out_ready_o always 1 outside FLUSH): pop id FIFO, push
//   {id,status,result} to response FIFO; inflight--. Issue+capture same cycle: inflight unchanged.
//  Capture with inflight==0 (spurious): dropped, no push; rsp unaffected.
//  Response FIFO: first-word-fall-through; rsp_* valid same cycle as rsp_valid_o; pop on valid&ready.
//   Push and pop in same cycle when full is legal (count unchanged). Capture-to-rsp_valid_o latency 1 cycle.
//  FSM: IDLE (inflight==0) -> BUSY on issue; BUSY -> IDLE when inflight reaches 0;
//   BUSY: wdog counter resets on every capture, increments otherwise; wdog==TIMEOUT-1 -> FLUSH, set timeout_o.
//   Any state: flush_i -> FLUSH (flush_i has priority over issue/capture that cycle: neither takes effect).
//   FLUSH: exactly 1 cycle; div_flush_o=1, div_valid_o=0, job_ready_o=0, div_out_ready_o=0;
//   clears id FIFO, response FIFO, inflight, wdog; next state IDLE.
//  rst_i mid-operation: identical clearing to FLUSH but without div_flush_o pulse; timeout_o cleared.
//  Ordering: complex_div returns results in issue order; rsp_id_o order equals job accept order.
// TESTING
//  1) Single job a=1,b=2,c=3,d=4 -> one rsp, id=job id, re=0.44, im=0.08, status=0, inflight back to 0.
//  2) 8 back-to-back jobs ids 0..7, rsp_ready_i=1 -> ids 0..7 in order, inflight never exceeds MAX_OUT=4.
//  3) rsp_ready_i=0, 6 jobs offered -> exactly 4 accepted, job_ready_o low after; release -> 4 rsps, then rest.
//  4) c=d=0 -> rsp_status_o DZ and/or NV set per divider, id preserved, flow continues.
//  5) Divider stalls out_valid with 2 in flight -> after TIMEOUT cycles 1-cycle div_flush_o, timeout_o=1, inflight=0.
//  6) flush_i same cycle as issue and capture -> neither counted, all FIFOs empty next cycle, no rsp emitted.

Source files
------------

// File: rtl/cdiv_issue_ctrl.sv
// cdiv_issue_ctrl: initiator-side controller for the complex_div unit.
// Jobs pass straight through to the divider whenever issue credit is
// available. Each issued job's id is queued in issue order. Divider results
// are paired with those ids in a first-word-fall-through response FIFO.
// Credit is counted so that every in-flight job already owns a response
// slot, which is why the divider's out_ready can stay high. A watchdog
// flushes a divider that stops returning results.
module cdiv_issue_ctrl #(
    parameter int WIDTH     = 64,
    parameter int ID_W      = 4,
    parameter int MAX_OUT   = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [4*WIDTH-1:0]         job_ops_i,
    input  logic [ID_W-1:0]            job_id_i,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    output logic [4*WIDTH-1:0]         div_ops_o,
    output logic                       div_flush_o,
    input  logic                       div_out_valid_i,
    output logic                       div_out_ready_o,
    input  logic [2*WIDTH-1:0]         div_result_i,
    input  logic [4:0]                 div_status_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [2*WIDTH-1:0]         rsp_result_o,
    output logic [4:0]                 rsp_status_o,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic [$clog2(MAX_OUT):0]   inflight_o,
    output logic                       timeout_o
);

    localparam int IPW  = $clog2(MAX_OUT);
    localparam int IFW  = IPW + 1;
    localparam int RPW  = $clog2(RSP_DEPTH);
    localparam int RCW  = RPW + 1;
    localparam int SUMW = ((IFW > RCW) ? IFW : RCW) + 1;
    localparam int WDW  = $clog2(TIMEOUT) + 1;

    localparam logic [IFW-1:0]  MAX_OUT_C   = IFW'(MAX_OUT);
    localparam logic [SUMW-1:0] RSP_DEPTH_C = SUMW'(RSP_DEPTH);
    localparam logic [WDW-1:0]  WDOG_LAST   = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [4:0]         status;
        logic [2*WIDTH-1:0] result;
    } rsp_ent_t;

    // Control state
    state_t           state_q;
    logic [WDW-1:0]   wdog_q;
    logic             tmo_q;
    logic             div_flush_q;
    logic             out_rdy_q;

    // Counters and FIFO pointers
    logic [IFW-1:0]   inflight_q, inflight_d;
    logic [IPW-1:0]   id_wptr_q, id_wptr_d;
    logic [IPW-1:0]   id_rptr_q, id_rptr_d;
    logic [RPW-1:0]   rsp_wptr_q, rsp_wptr_d;
    logic [RPW-1:0]   rsp_rptr_q, rsp_rptr_d;
    logic [RCW-1:0]   rsp_cnt_q, rsp_cnt_d;

    // Storage (data only, never reset)
    logic [ID_W-1:0]  id_mem_q [MAX_OUT];
    rsp_ent_t         rsp_mem_q [RSP_DEPTH];
    rsp_ent_t         rsp_head;

    // Per-cycle events
    logic             in_flush;
    logic [SUMW-1:0]  occupancy;
    logic             credit;
    logic             issue;
    logic             cap_raw;
    logic             capture;
    logic             rsp_pop;
    logic             timeout_hit;
    logic             go_flush;
    logic             clear;

    assign in_flush  = (state_q == ST_FLUSH);

    // A job may only be issued when the divider has room and its eventual
    // result is guaranteed a response slot (in flight + already buffered).
    assign occupancy = SUMW'(inflight_q) + SUMW'(rsp_cnt_q);
    assign credit    = (inflight_q < MAX_OUT_C) && (occupancy < RSP_DEPTH_C);

    assign div_valid_o = job_valid_i & credit & ~in_flush;
    assign job_ready_o = div_ready_i & credit & ~in_flush;
    assign div_ops_o   = job_ops_i;

    // flush_i overrides any issue or capture presented in the same cycle.
    assign issue   = div_valid_o & div_ready_i & ~flush_i;
    assign cap_raw = div_out_valid_i & div_out_ready_o;
    // A result arriving with nothing in flight has no id to pair with; drop it.
    assign capture = cap_raw & ~flush_i & (inflight_q != '0);
    assign rsp_pop = rsp_valid_o & rsp_ready_i;

    assign timeout_hit = (state_q == ST_BUSY) & ~cap_raw & (wdog_q == WDOG_LAST) & ~flush_i;
    assign go_flush    = flush_i | timeout_hit;
    // Queues are emptied on the edge that enters FLUSH and held empty during it,
    // so nothing stale is ever presented on rsp_* after a flush request.
    assign clear       = go_flush | in_flush;

    assign rsp_head     = rsp_mem_q[rsp_rptr_q];
    assign rsp_valid_o  = (rsp_cnt_q != '0);
    assign rsp_result_o = rsp_valid_o ? rsp_head.result : '0;
    assign rsp_status_o = rsp_valid_o ? rsp_head.status : '0;
    assign rsp_id_o     = rsp_valid_o ? rsp_head.id     : '0;

    assign inflight_o      = inflight_q;
    assign timeout_o       = tmo_q;
    assign div_flush_o     = div_flush_q;
    assign div_out_ready_o = out_rdy_q;

    // Next-state for the in-flight count and both FIFOs' pointers/occupancy.
    always_comb begin
        inflight_d = inflight_q;
        id_wptr_d  = id_wptr_q;
        id_rptr_d  = id_rptr_q;
        rsp_wptr_d = rsp_wptr_q;
        rsp_rptr_d = rsp_rptr_q;
        rsp_cnt_d  = rsp_cnt_q;
        if (clear) begin
            inflight_d = '0;
            id_wptr_d  = '0;
            id_rptr_d  = '0;
            rsp_wptr_d = '0;
            rsp_rptr_d = '0;
            rsp_cnt_d  = '0;
        end else begin
            if (issue) begin
                id_wptr_d = id_wptr_q + IPW'(1);
            end
            if (capture) begin
                id_rptr_d  = id_rptr_q + IPW'(1);
                rsp_wptr_d = rsp_wptr_q + RPW'(1);
            end
            if (rsp_pop) begin
                rsp_rptr_d = rsp_rptr_q + RPW'(1);
            end
            if (issue && !capture) begin
                inflight_d = inflight_q + IFW'(1);
            end else if (!issue && capture) begin
                inflight_d = inflight_q - IFW'(1);
            end
            if (capture && !rsp_pop) begin
                rsp_cnt_d = rsp_cnt_q + RCW'(1);
            end else if (!capture && rsp_pop) begin
                rsp_cnt_d = rsp_cnt_q - RCW'(1);
            end
        end
    end

    // Counter and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            id_wptr_q  <= '0;
            id_rptr_q  <= '0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            id_wptr_q  <= id_wptr_d;
            id_rptr_q  <= id_rptr_d;
            rsp_wptr_q <= rsp_wptr_d;
            rsp_rptr_q <= rsp_rptr_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    // FIFO storage writes: id on issue, tagged result on capture.
    always_ff @(posedge clk_i) begin
        if (issue && !clear) begin
            id_mem_q[id_wptr_q] <= job_id_i;
        end
        if (capture && !clear) begin
            rsp_mem_q[rsp_wptr_q] <= '{id:     id_mem_q[id_rptr_q],
                                       status: div_status_i,
                                       result: div_result_i};
        end
    end

    // Controller FSM with watchdog, sticky timeout flag and registered divider controls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wdog_q      <= '0;
            tmo_q       <= 1'b0;
            div_flush_q <= 1'b0;
            out_rdy_q   <= 1'b1;
        end else begin
            div_flush_q <= go_flush;
            out_rdy_q   <= ~go_flush;
            if (go_flush) begin
                state_q <= ST_FLUSH;
                wdog_q  <= '0;
                if (timeout_hit) begin
                    tmo_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        wdog_q <= '0;
                        if (issue) begin
                            state_q <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (inflight_d == '0) begin
                            state_q <= ST_IDLE;
                            wdog_q  <= '0;
                        end else if (capture) begin
                            wdog_q <= '0;
                        end else begin
                            wdog_q <= wdog_q + WDW'(1);
                        end
                    end
                    ST_FLUSH: begin
                        state_q <= ST_IDLE;
                        wdog_q  <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        wdog_q  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
